cpu_trace_buffer: RTL
=====================

Name: cpu_trace_buffer

Overview:
- Debug trace capture stage directly downstream of the CPU core; consumes the core's debug outputs (Addr, Result, ALU operand/result buses).
- Records one entry per new instruction address into a circular buffer, with an address trigger and post-trigger window.
- After the window closes, the buffer freezes and is drained over a valid/ready read port by a host or debug UART.

Parameters:
DEPTH, 16, number of trace records; power of 2, minimum 2
PTR_W, 4, log2(DEPTH); width of the read and write pointers
POST_TRIG, 8, records captured after the trigger record; 0 to DEPTH-1

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Enable  in  1  arm request; low forces IDLE
TrigAddr  in  32  trigger instruction address
Addr  in  32  CPU current instruction address
Result  in  32  CPU writeback result
ALUin1  in  32  CPU ALU operand 1
ALUin2  in  32  CPU ALU operand 2
ALUout  in  32  CPU ALU result
RdValid  out  1  record available on RdData
RdReady  in  1  consumer accepts record
RdData  out  96  {Addr, ALUout, Result} of the oldest record
Count  out  PTR_W+1  number of records held
Overflow  out  1  sticky; a record was overwritten
State  out  2  0=IDLE, 1=ARMED, 2=POST, 3=FROZEN

Behaviour:
- Reset (Reset=0, asynchronous) clears:
  - State=IDLE, pointers, Count=0, Overflow=0, post counter, PrevAddr=0, First=1.
  - RdValid=0; RdData is don't-care while RdValid=0.
- Capture condition cap = (First || Addr != PrevAddr).
  - Evaluated only in ARMED and POST.
  - On cap, the record is written at the rising edge of the sampled cycle; PrevAddr<=Addr and First<=0 at that same edge.
  - Count reflects the write one cycle later (registered).
- IDLE:
  - No capture; RdValid=0.
  - Enable=1 -> ARMED. On that edge: pointers, Count, Overflow and post counter clear; First<=1.
- ARMED:
  - Capture on cap.
  - Full (Count==DEPTH) and cap: overwrite the oldest record, advance wr_ptr and rd_ptr together, Count stays DEPTH, Overflow<=1.
  - cap && Addr==TrigAddr: trigger record is written.
    - POST_TRIG==0 -> FROZEN.
    - Otherwise -> POST with post counter=POST_TRIG.
- POST:
  - Same capture and overwrite rules as ARMED; TrigAddr is ignored.
  - Each cap decrements the post counter; the capture that brings it to 0 -> FROZEN on that edge.
- FROZEN:
  - No capture.
  - RdValid = (Count!=0).
  - RdData = mem[rd_ptr], combinational first-word-fall-through.
  - Pop on RdValid && RdReady: rd_ptr++ (wraps mod DEPTH), Count--.
  - RdReady while Count==0 is ignored.
  - Remains FROZEN with Count==0 until Enable=0.
- Enable=0 in any state -> IDLE next edge. Buffer contents are retained but not readable; the next arm clears them.
- Reset mid-capture or mid-drain: immediate return to reset values; no partial record survives.
- Pointer arithmetic is modulo DEPTH. Count saturates at DEPTH and never exceeds it.
- Only ARMED/POST writes and only FROZEN reads, so write and read never occur in the same cycle.

Decomposition:
- Shared package cpu_dbg_pkg:
  - State encodings ST_IDLE/ST_ARMED/ST_POST/ST_FROZEN.
  - Record width REC_W=96.
  - Field offsets for Addr/ALUout/Result.
- One sub-module, trace_ram: DEPTH x REC_W, one write port, asynchronous read port.
- Control FSM, pointers and counters stay in cpu_trace_buffer.

Test Plan:
- Reset asserted mid-ARMED with Count=5 -> State=0, Count=0, Overflow=0, RdValid=0 immediately, without waiting for a clock edge.
- Enable=1; Addr=0,4,4,8; TrigAddr=8; POST_TRIG=2; then Addr=C,10 -> FROZEN, Count=5, records in order 0,4,8,C,10 (repeated 4 not captured).
- Continue from the previous scenario with RdReady held at 1 -> five RdData beats on consecutive cycles, RdValid drops after the fifth, Count=0; extra RdReady pulses change nothing.
- DEPTH=16; 20 distinct addresses 0..4C step 4 before trigger at 50; POST_TRIG=0 -> Overflow=1, Count=16, first record read is Addr=14.
- Consumer stalls: RdReady=0 for 3 cycles in FROZEN -> RdData stable, Count unchanged; one RdReady pulse -> exactly one pop.
- Enable dropped in POST after 1 of 2 post records -> IDLE, RdValid=0. Re-arm -> Count=0, Overflow=0; first capture occurs even if Addr equals the last captured address.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared state encodings and trace record layout for the CPU debug trace path
package cpu_dbg_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;
    localparam int REC_W      = 96;
    localparam int ADDR_LSB   = 64;
    localparam int ALUOUT_LSB = 32;
    localparam int RESULT_LSB = 0;
    function automatic logic [REC_W-1:0] pack_rec(input logic [31:0] addr, input logic [31:0] alu_out,
                                                  input logic [31:0] result);
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[ADDR_LSB +: 32]   = addr;
        rec[ALUOUT_LSB +: 32] = alu_out;
        rec[RESULT_LSB +: 32] = result;
        return rec;
    endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x REC_W record store, one synchronous write port and one asynchronous read port
module trace_ram
    import cpu_dbg_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [REC_W-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [REC_W-1:0] rdata
);
    logic [REC_W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular trace capture of new instruction addresses with address trigger and drain port
module cpu_trace_buffer
    import cpu_dbg_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4,
    parameter int POST_TRIG = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [31:0]      TrigAddr,
    input  logic [31:0]      Addr,
    input  logic [31:0]      Result,
    input  logic [31:0]      ALUin1,
    input  logic [31:0]      ALUin2,
    input  logic [31:0]      ALUout,
    output logic             RdValid,
    input  logic             RdReady,
    output logic [REC_W-1:0] RdData,
    output logic [PTR_W:0]   Count,
    output logic             Overflow,
    output logic [1:0]       State
);
    localparam logic [PTR_W:0]   FULL      = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_TRIG);
    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_q, post_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d, first_q, first_d;
    logic [31:0]      prev_addr_q, prev_addr_d;
    logic             cap, pop, unused_alu_in;
    // Operands are part of the core's debug bus but not recorded
    assign unused_alu_in = ^{ALUin1, ALUin2};
    assign cap     = Enable && (state_q == ST_ARMED || state_q == ST_POST) && (first_q || Addr != prev_addr_q);
    assign RdValid = state_q == ST_FROZEN && count_q != '0;
    assign pop     = RdValid && RdReady;
    assign Count    = count_q;
    assign Overflow = overflow_q;
    assign State    = state_q;
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        post_d      = post_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        first_d     = first_q;
        prev_addr_d = prev_addr_q;
        if (!Enable) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            post_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            first_d    = 1'b1;
        end else if (cap) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            prev_addr_d = Addr;
            first_d     = 1'b0;
            // A full buffer drops its oldest record so the window keeps sliding
            if (count_q == FULL) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            if (state_q == ST_ARMED && Addr == TrigAddr) begin
                state_d = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
                post_d  = POST_INIT;
            end else if (state_q == ST_POST) begin
                post_d  = post_q - 1'b1;
                state_d = (post_q == PTR_W'(1)) ? ST_FROZEN : ST_POST;
            end
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            first_q     <= 1'b1;
            prev_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            post_q      <= post_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            first_q     <= first_d;
            prev_addr_q <= prev_addr_d;
        end
    end
    trace_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
        .clk  (Clock),
        .we   (cap),
        .waddr(wr_ptr_q),
        .wdata(pack_rec(Addr, ALUout, Result)),
        .raddr(rd_ptr_q),
        .rdata(RdData)
    );
endmodule
